// File: rtl/datapath_seq_unit_pkg.sv
// Shared types and constants for the switch-driven operand/result datapath.
// Holds the FSM state encoding, the blank segment pattern and the hex-to-segment decoder.
// Pure declarations; no logic and no ports.
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        SHOW    = 3'd4
    } state_t;

    // All segments off (segments are active-low, ordered g..a).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        logic [6:0] seg;
        case (h)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/datapath_seq_unit_if.sv
// Board-side bundle of the datapath: switch byte, enter key, load/mode controls, status and displays.
// master drives the controls (board/controller side); slave is the datapath itself.
// Ports: enter, inputdata[7:0], loaddata, mode -> ; inputdata_ready, busy, done, disp[7*NDIGITS-1:0] <-.
interface datapath_seq_unit_if #(
    parameter int NDIGITS = 4
);
    logic                   enter;
    logic [7:0]             inputdata;
    logic                   loaddata;
    logic                   mode;
    logic                   inputdata_ready;
    logic                   busy;
    logic                   done;
    logic [7*NDIGITS-1:0]   disp;

    modport master (
        output enter, inputdata, loaddata, mode,
        input  inputdata_ready, busy, done, disp
    );

    modport slave (
        input  enter, inputdata, loaddata, mode,
        output inputdata_ready, busy, done, disp
    );
endinterface

// File: rtl/datapath_seq_unit_seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, WIDTH iterations after start.
// Ports: clk, rst (sync, active-high), clr (abort + zero), start, a, b; busy, done, product[2*WIDTH-1:0].
// done is high during the final iteration: product is valid from the following edge onward.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;
    logic [CNTW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH:0]     sum;

    // prod_q holds {partial sum, remaining multiplier bits}; the carry bit of the
    // upper-half add shifts back in from the top so nothing is lost.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (clr) begin
            mcand_d = '0;
            prod_d  = '0;
            cnt_d   = '0;
        end else if (start) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = CNTW'(WIDTH);
        end else if (cnt_q != '0) begin
            prod_d  = {sum, prod_q[WIDTH-1:1]};
            cnt_d   = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = (cnt_q == CNTW'(1));
    assign product = prod_q;

endmodule

// File: rtl/datapath_seq_unit.sv
// Loads two WIDTH-bit operands byte-wise from switches, multiplies (shift-add) or adds, pages result in hex.
// Ports: clk, reset (sync, active-high), io (slave modport: enter/inputdata/loaddata/mode in; ready/busy/done/disp out).
// Multiply keeps busy for WIDTH cycles, add for one; loaddata restarts from any state and beats a same-cycle enter.
module datapath_seq_unit
    import datapath_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    datapath_seq_unit_if.slave   io
);
    localparam int NBYTES    = WIDTH / 8;
    localparam int CW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int PAGE_BITS = 4 * NDIGITS;
    localparam int NPAGES    = (2 * WIDTH) / PAGE_BITS;
    localparam int PW        = (NPAGES > 1) ? $clog2(NPAGES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [PW-1:0] LAST_PAGE = PW'(NPAGES - 1);

    state_t               state_q, state_d;
    logic                 enter_q, enter_d;
    logic                 mode_q, mode_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [PW-1:0]        page_q, page_d;

    logic                 enter_evt;
    logic [WIDTH-1:0]     a_shift, b_shift;
    logic [WIDTH:0]       sum;
    logic                 mul_start, mul_clr, mul_busy, mul_done;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [2*WIDTH-1:0]   res_sel;
    logic [PAGE_BITS-1:0] show_bits;
    logic                 blank;
    logic [7*NDIGITS-1:0] disp_w;

    assign enter_evt = io.enter & ~enter_q;
    assign a_shift   = WIDTH'({op_a_q, io.inputdata});
    assign b_shift   = WIDTH'({op_b_q, io.inputdata});
    assign sum       = {1'b0, op_a_q} + {1'b0, op_b_q};

    // Fed with b_shift so the multiplier starts on the same edge that stores the last B byte.
    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (reset),
        .clr     (mul_clr),
        .start   (mul_start),
        .a       (op_a_q),
        .b       (b_shift),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        enter_d   = io.enter;
        mode_d    = mode_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        page_d    = page_q;
        mul_start = 1'b0;
        mul_clr   = 1'b0;
        if (io.loaddata) begin
            state_d  = LOAD_A;
            op_a_d   = '0;
            op_b_d   = '0;
            cnt_d    = '0;
            result_d = '0;
            page_d   = '0;
            mul_clr  = 1'b1;
        end else begin
            case (state_q)
                LOAD_A: if (enter_evt) begin
                    op_a_d = a_shift;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                LOAD_B: if (enter_evt) begin
                    op_b_d = b_shift;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d     = '0;
                        state_d   = COMPUTE;
                        mode_d    = io.mode;
                        mul_start = ~io.mode;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                COMPUTE: begin
                    if (mode_q) begin
                        result_d = (2*WIDTH)'(sum);
                        state_d  = SHOW;
                        page_d   = '0;
                    end else if (mul_done || !mul_busy) begin
                        // An idle multiplier here can only mean it was never started; don't stall.
                        state_d = SHOW;
                        page_d  = '0;
                    end
                end
                SHOW: if (enter_evt) begin
                    page_d = (page_q == LAST_PAGE) ? '0 : page_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            enter_q  <= 1'b0;
            mode_q   <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            page_q   <= '0;
        end else begin
            state_q  <= state_d;
            enter_q  <= enter_d;
            mode_q   <= mode_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            page_q   <= page_d;
        end
    end

    // Add results live in result_q; multiply results stay in the multiplier's product register.
    assign res_sel = mode_q ? result_q : mul_prod;

    always_comb begin
        show_bits = '0;
        blank     = 1'b1;
        case (state_q)
            LOAD_A: begin
                show_bits = PAGE_BITS'((2*WIDTH)'(op_a_q));
                blank     = 1'b0;
            end
            LOAD_B: begin
                show_bits = PAGE_BITS'((2*WIDTH)'(op_b_q));
                blank     = 1'b0;
            end
            SHOW: begin
                show_bits = res_sel[page_q*PAGE_BITS +: PAGE_BITS];
                blank     = 1'b0;
            end
            default: ;
        endcase
        disp_w = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            disp_w[7*i +: 7] = blank ? SEG_OFF : hex7seg(show_bits[4*i +: 4]);
        end
    end

    assign io.disp            = disp_w;
    assign io.inputdata_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign io.busy            = (state_q == COMPUTE);
    assign io.done            = (state_q == SHOW);

endmodule

// File: tb/tb_datapath_seq_unit.sv
// Self-checking bench for datapath_seq_unit (WIDTH=32, NDIGITS=4).
// Expected display pages are pushed to a scoreboard queue when operands are driven and popped while paging.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge.
module tb_datapath_seq_unit;
    localparam int WIDTH   = 32;
    localparam int NDIGITS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datapath_seq_unit_if #(.NDIGITS(NDIGITS)) io ();

    datapath_seq_unit #(.WIDTH(WIDTH), .NDIGITS(NDIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [27:0] enc(input logic [15:0] v);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = seg_tab[v[4*i +: 4]];
        return r;
    endfunction

    task automatic press(input logic [7:0] b);
        @(negedge clk);
        io.inputdata = b;
        io.enter     = 1'b1;
        @(negedge clk);
        io.enter     = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        io.loaddata = 1'b1;
        @(negedge clk);
        io.loaddata = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] v);
        for (int i = 0; i < 4; i++) press(v[31-8*i -: 8]);
    endtask

    task automatic push_pages(input logic [63:0] r);
        for (int p = 0; p < 4; p++) exp_q.push_back(r[16*p +: 16]);
    endtask

    // Counts busy cycles (bounded) right after the last operand byte, then checks done.
    task automatic wait_compute(input int exp_busy, input string name);
        int n = 0;
        while (io.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_busy);
        end
        checks++;
        if (io.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b expected 1", name, io.done);
        end
    endtask

    // Pops expected pages from the scoreboard, compares the display, presses enter to advance.
    task automatic show_pages(input int n, input string name);
        logic [15:0] e;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s page%0d: scoreboard empty", name, k);
            end else begin
                e = exp_q.pop_front();
                if (io.disp !== enc(e)) begin
                    errors++;
                    $display("FAIL %s page%0d disp: got %h expected %h (%h)", name, k, io.disp, enc(e), e);
                end
            end
            press(8'h00);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io.enter = 1'b0; io.inputdata = 8'h00; io.loaddata = 1'b0; io.mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (io.disp !== {NDIGITS{7'h7F}}) begin errors++; $display("FAIL reset disp: got %h expected all 7F", io.disp); end
        checks++;
        if (io.inputdata_ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b expected 0", io.inputdata_ready); end
        checks++;
        if (io.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", io.busy); end
        checks++;
        if (io.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", io.done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small_mul();
        io.mode = 1'b0;
        pulse_load();
        checks++;
        if (io.inputdata_ready !== 1'b1) begin errors++; $display("FAIL small ready: got %b expected 1", io.inputdata_ready); end
        load_word(32'h0000_0003);
        load_word(32'h0000_0005);
        push_pages(64'd3 * 64'd5);
        wait_compute(32, "small_mul");
        show_pages(4, "small_mul");
    endtask

    task automatic test_max_mul();
        logic [63:0] r;
        io.mode = 1'b0;
        pulse_load();
        load_word(32'hFFFF_FFFF);
        load_word(32'hFFFF_FFFF);
        r = 64'hFFFF_FFFF * 64'hFFFF_FFFF;
        push_pages(r);
        exp_q.push_back(r[15:0]);   // fifth press wraps to page 0
        wait_compute(32, "max_mul");
        show_pages(5, "max_mul");
    endtask

    task automatic test_add_carry();
        io.mode = 1'b1;
        pulse_load();
        load_word(32'hFFFF_FFFF);
        load_word(32'h0000_0001);
        push_pages(64'hFFFF_FFFF + 64'h1);
        wait_compute(1, "add_carry");
        show_pages(4, "add_carry");
        io.mode = 1'b0;
    endtask

    task automatic test_restart();
        io.mode = 1'b0;
        pulse_load();
        press(8'h12);
        press(8'h34);
        checks++;
        if (io.disp !== enc(16'h1234)) begin errors++; $display("FAIL restart echo: got %h expected %h", io.disp, enc(16'h1234)); end
        @(negedge clk);
        io.loaddata = 1'b1; io.enter = 1'b1; io.inputdata = 8'h56;
        @(negedge clk);
        io.loaddata = 1'b0; io.enter = 1'b0;
        checks++;
        if (io.disp !== enc(16'h0000)) begin errors++; $display("FAIL restart cleared: got %h expected %h", io.disp, enc(16'h0000)); end
        load_word(32'h0000_ABCD);
        load_word(32'h0001_0002);
        push_pages(64'h0000_ABCD * 64'h0001_0002);
        wait_compute(32, "restart");
        show_pages(4, "restart");
    endtask

    task automatic test_reset_compute();
        io.mode = 1'b0;
        pulse_load();
        load_word(32'h1234_5678);
        load_word(32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (io.busy !== 1'b0) begin errors++; $display("FAIL rst_compute busy: got %b expected 0", io.busy); end
        checks++;
        if (io.disp !== {NDIGITS{7'h7F}}) begin errors++; $display("FAIL rst_compute disp: got %h expected all 7F", io.disp); end
        checks++;
        if (io.inputdata_ready !== 1'b0) begin errors++; $display("FAIL rst_compute ready: got %b expected 0", io.inputdata_ready); end
        repeat (40) @(negedge clk);
        checks++;
        if (io.done !== 1'b0 || io.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_compute idle: got done=%b busy=%b expected 0/0", io.done, io.busy);
        end
    endtask

    task automatic test_held_enter();
        io.mode = 1'b0;
        pulse_load();
        @(negedge clk);
        io.inputdata = 8'h02;
        io.enter     = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            io.inputdata = 8'(8'h90 + i);
        end
        @(negedge clk);
        io.enter = 1'b0;
        checks++;
        if (io.disp !== enc(16'h0002)) begin errors++; $display("FAIL held echo: got %h expected %h", io.disp, enc(16'h0002)); end
        press(8'h00); press(8'h00); press(8'h00);
        load_word(32'h0000_0003);
        push_pages(64'h0200_0000 * 64'd3);
        wait_compute(32, "held");
        show_pages(4, "held");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_small_mul();
        test_max_mul();
        test_add_carry();
        test_restart();
        test_reset_compute();
        test_held_enter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
